axis_rx_frame_filter: RTL

- Single-clock AXI4-Stream stage that consumes RX frames leaving the MAC-side async FIFO (m_axis of the CDC FIFO, m_clk domain).
- Counts bytes per frame, flags runt frames and truncates oversize frames (forced tlast, tuser bad), and discards the truncated remainder.
- Emits a one-cycle per-frame status pulse with the forwarded length.
- Output is one registered beat, feeding the RX DMA/buffer writer.

---
 rtl/eth_rx_pkg.sv | 19 +
 rtl/axis_rx_frame_filter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/eth_rx_pkg.sv
// Shared types and Ethernet length limits for the RX frame path.
package eth_rx_pkg;

  typedef enum logic {
    PASS    = 1'b0,
    DISCARD = 1'b1
  } state_e;

  localparam int ETH_MIN_LEN = 64;
  localparam int ETH_MAX_LEN = 1518;
  localparam int ETH_LEN_W   = $clog2(ETH_MAX_LEN + 1);

  typedef struct packed {
    logic [ETH_LEN_W-1:0] len;
    logic                 runt;
    logic                 trunc;
  } eth_status_t;

endpackage

// File: rtl/axis_rx_frame_filter.sv
// RX frame filter: counts bytes per frame, marks runts, truncates oversize frames
// and drops their remainder; one registered output beat plus a per-frame status pulse.
module axis_rx_frame_filter
  import eth_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int MIN_LEN    = ETH_MIN_LEN,
  parameter int MAX_LEN    = ETH_MAX_LEN,
  parameter int LEN_WIDTH  = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Handshake: a beat moves only in a cycle where tvalid and tready are both
  // high; a held m_axis beat stays stable until m_axis_tready is seen.
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  status_valid,
  output logic [LEN_WIDTH-1:0]  status_len,
  output logic                  status_runt,
  output logic                  status_trunc,
  output state_e                dbg_state
);

  localparam logic [LEN_WIDTH:0] C_MIN = (LEN_WIDTH + 1)'(MIN_LEN);
  localparam logic [LEN_WIDTH:0] C_MAX = (LEN_WIDTH + 1)'(MAX_LEN);

  state_e                r_state;
  state_e                w_state_next;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic                  r_bad;
  logic [LEN_WIDTH:0]    w_nbytes;
  logic [LEN_WIDTH:0]    w_cnt_next;
  logic                  w_in_fire;
  logic                  w_pass_fire;
  logic                  w_runt;
  logic                  w_trunc;
  logic                  w_end;

  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic [KEEP_WIDTH-1:0] r_m_tkeep;
  logic                  r_m_tvalid;
  logic                  r_m_tlast;
  logic                  r_m_tuser;
  logic                  r_st_valid;
  logic [LEN_WIDTH-1:0]  r_st_len;
  logic                  r_st_runt;
  logic                  r_st_trunc;

  always_comb begin
    w_nbytes = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      w_nbytes = w_nbytes + {{LEN_WIDTH{1'b0}}, s_axis_tkeep[i]};
    end
  end

  // The discard path never touches the output register, so it can always sink.
  assign s_axis_tready = (r_state == DISCARD) | ~r_m_tvalid | m_axis_tready;
  assign w_in_fire     = s_axis_tvalid & s_axis_tready;
  assign w_pass_fire   = w_in_fire & (r_state == PASS);
  assign w_cnt_next    = {1'b0, r_cnt} + w_nbytes;
  assign w_runt        = s_axis_tlast & (w_cnt_next < C_MIN);
  assign w_trunc       = ~s_axis_tlast & (w_cnt_next >= C_MAX);
  assign w_end         = s_axis_tlast | w_trunc;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      PASS:    if (w_in_fire && w_trunc)      w_state_next = DISCARD;
      DISCARD: if (w_in_fire && s_axis_tlast) w_state_next = PASS;
      default: w_state_next = PASS;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PASS;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_bad <= 1'b0;
    end else if (w_pass_fire) begin
      if (w_end) begin
        r_cnt <= '0;
        r_bad <= 1'b0;
      end else begin
        r_cnt <= w_cnt_next[LEN_WIDTH-1:0];
        r_bad <= r_bad | s_axis_tuser;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tuser  <= 1'b0;
    end else if (w_pass_fire) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= s_axis_tdata;
      r_m_tkeep  <= s_axis_tkeep;
      r_m_tlast  <= w_end;
      r_m_tuser  <= w_trunc | (s_axis_tlast & (r_bad | s_axis_tuser | w_runt));
    end else if (m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  // Status is loaded on the same edge as the frame's last output beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st_valid <= 1'b0;
      r_st_len   <= '0;
      r_st_runt  <= 1'b0;
      r_st_trunc <= 1'b0;
    end else begin
      r_st_valid <= w_pass_fire & w_end;
      if (w_pass_fire && w_end) begin
        r_st_len   <= w_trunc ? C_MAX[LEN_WIDTH-1:0] : w_cnt_next[LEN_WIDTH-1:0];
        r_st_runt  <= w_runt;
        r_st_trunc <= w_trunc;
      end
    end
  end

  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tkeep  = r_m_tkeep;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign m_axis_tuser  = r_m_tuser;
  assign status_valid  = r_st_valid;
  assign status_len    = r_st_len;
  assign status_runt   = r_st_runt;
  assign status_trunc  = r_st_trunc;
  assign dbg_state     = r_state;

endmodule
